// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle and returns a registered result with a one-cycle done pulse.
module div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;

  logic [1:0]     op_r;
  logic           neg_q_r;
  logic           neg_r_r;
  logic [N-1:0]   divisor_r;
  logic [N:0]     rem_r;
  logic [N-1:0]   quo_r;
  logic [CW-1:0]  cnt_r;
  logic [N-1:0]   out_r;
  logic           dbz_r;

  logic           accept;
  logic           op_signed;
  logic           sign_a;
  logic           sign_b;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic           is_zero;
  logic           is_ovf;
  logic           special;

  logic [N:0]     shifted;
  logic [N:0]     trial;
  logic [N:0]     rem_nx;
  logic [N-1:0]   quo_nx;
  logic [N-1:0]   q_fix;
  logic [N-1:0]   r_fix;
  logic [N-1:0]   result;

  // Request decode: signed ops are DIV/REM (op[0] == 0).
  always_comb begin
    accept    = start && (state != CALC);
    op_signed = ~op[0];
    sign_a    = op_signed & inA[N-1];
    sign_b    = op_signed & inB[N-1];
    abs_a     = sign_a ? (~inA + 1'b1) : inA;
    abs_b     = sign_b ? (~inB + 1'b1) : inB;
    is_zero   = (inB == '0);
    is_ovf    = op_signed && (inA == {1'b1, {(N-1){1'b0}}}) && (inB == '1);
    special   = is_zero || is_ovf;
  end

  // One restoring step, plus the sign correction applied on the final step.
  always_comb begin
    shifted = {rem_r[N-1:0], quo_r[N-1]};
    trial   = shifted - {1'b0, divisor_r};
    rem_nx  = trial[N] ? shifted : trial;
    quo_nx  = {quo_r[N-2:0], ~trial[N]};
    q_fix   = neg_q_r ? (~quo_nx + 1'b1) : quo_nx;
    r_fix   = neg_r_r ? (~rem_nx[N-1:0] + 1'b1) : rem_nx[N-1:0];
    result  = op_r[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_r == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nx = special ? DONE : CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, iteration registers and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= '0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      divisor_r <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      cnt_r     <= '0;
      out_r     <= '0;
      dbz_r     <= 1'b0;
    end else if (accept) begin
      op_r      <= op;
      neg_q_r   <= sign_a ^ sign_b;
      neg_r_r   <= sign_a;
      divisor_r <= abs_b;
      rem_r     <= '0;
      quo_r     <= abs_a;
      cnt_r     <= CW'(N - 1);
      dbz_r     <= is_zero;
      if (is_zero) begin
        out_r <= op[1] ? inA : '1;
      end else if (is_ovf) begin
        out_r <= op[1] ? '0 : inA;
      end
    end else if (state == CALC) begin
      rem_r <= rem_nx;
      quo_r <= quo_nx;
      cnt_r <= cnt_r - 1'b1;
      if (cnt_r == '0) begin
        out_r <= result;
      end
    end
  end

  assign busy        = (state == CALC);
  assign done        = (state == DONE);
  assign out         = out_r;
  assign div_by_zero = dbz_r;

endmodule
